// File: rtl/checker_pkg.sv
// Shared definitions for the checker arbiter: FSM states, framing characters
// and the verdict codes returned by the cpu_checker.
package checker_pkg;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_BUSY   = 2'd1,
    ST_WAIT   = 2'd2,
    ST_REPORT = 2'd3
  } state_t;

  localparam logic [7:0] CH_START = 8'h5E;  // '^'
  localparam logic [7:0] CH_END   = 8'h23;  // '#'
  localparam logic [7:0] CH_IDLE  = 8'h00;

  localparam logic [1:0] FMT_INVALID  = 2'd0;
  localparam logic [1:0] FMT_REGISTER = 2'd1;
  localparam logic [1:0] FMT_MEMORY   = 2'd2;

  // Any nonzero verdict counts as a successfully parsed record.
  function automatic logic fmt_is_ok(input logic [1:0] fmt);
    return fmt != FMT_INVALID;
  endfunction

endpackage

// File: rtl/rr_arb2.sv
// Two-way round-robin grant: on a tie the requester not granted most recently
// wins; the last-grant memory updates on every grant.
module rr_arb2 (
  input  logic       clk,
  input  logic       reset,
  input  logic [1:0] req,
  output logic       gnt_valid,
  output logic       gnt_id
);

  logic last_reg, last_next;

  always_comb begin
    gnt_id = 1'b0;
    case (req)
      2'b01:   gnt_id = 1'b0;
      2'b10:   gnt_id = 1'b1;
      2'b11:   gnt_id = ~last_reg;
      default: gnt_id = 1'b0;
    endcase
    gnt_valid = |req;
    last_next = gnt_valid ? gnt_id : last_reg;
  end

  // Reset value 1 makes requester 0 win the first tie.
  always_ff @(posedge clk) begin
    if (!reset) begin
      last_reg <= 1'b1;
    end else begin
      last_reg <= last_next;
    end
  end

endmodule

// File: rtl/checker_arbiter.sv
// Shares one cpu_checker between two character-stream requesters: grants a
// record on '^', forwards it to the checker, and reports the verdict per owner.
module checker_arbiter
  import checker_pkg::*;
#(
  parameter int MAX_LEN = 64
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       req0_valid,
  input  logic       req1_valid,
  input  logic [7:0] req0_char,
  input  logic [7:0] req1_char,
  output logic       req0_ready,
  output logic       req1_ready,
  output logic [7:0] chk_char,
  input  logic [1:0] chk_format,
  output logic       res_valid,
  output logic       res_src,
  output logic [1:0] res_format,
  output logic [7:0] ok_cnt0,
  output logic [7:0] ok_cnt1
);

  localparam int LEN_W = $clog2(MAX_LEN) + 1;
  // Characters counted after '^'; at this value the incoming one is the last allowed.
  localparam logic [LEN_W-1:0] LEN_LAST = LEN_W'(MAX_LEN - 2);

  state_t           state_reg, state_next;
  logic [7:0]       chk_char_reg, chk_char_next;
  logic             owner_reg, owner_next;
  logic             abort_reg, abort_next;
  logic [LEN_W-1:0] len_reg, len_next;
  logic [1:0]       fmt_reg, fmt_next;
  logic             res_valid_reg, res_valid_next;
  logic             res_src_reg, res_src_next;
  logic [1:0]       res_format_reg, res_format_next;
  logic [7:0]       ok_cnt_reg [2];
  logic [1:0]       ok_inc;

  logic [1:0]       req_valid;
  logic [1:0][7:0]  req_char;
  logic [1:0]       ready;
  logic [1:0]       start_req;
  logic             grant_valid;
  logic             grant_id;
  logic             own_fire;
  logic [7:0]       own_char;

  assign req_valid = {req1_valid, req0_valid};
  assign req_char  = {req1_char, req0_char};

  for (genvar gi = 0; gi < 2; gi++) begin : g_req
    assign ready[gi] = reset &&
                       (((state_reg == ST_IDLE) && req_valid[gi]) ||
                        ((state_reg == ST_BUSY) && (owner_reg == 1'(gi))));
    assign start_req[gi] = (state_reg == ST_IDLE) && req_valid[gi] &&
                           (req_char[gi] == CH_START);
  end

  rr_arb2 u_rr_arb2 (
    .clk       (clk),
    .reset     (reset),
    .req       (start_req),
    .gnt_valid (grant_valid),
    .gnt_id    (grant_id)
  );

  // In BUSY the owner always sees ready, so its valid alone is the handshake.
  assign own_fire = req_valid[owner_reg];
  assign own_char = req_char[owner_reg];

  always_comb begin
    state_next      = state_reg;
    chk_char_next   = CH_IDLE;
    owner_next      = owner_reg;
    abort_next      = abort_reg;
    len_next        = len_reg;
    fmt_next        = fmt_reg;
    res_valid_next  = 1'b0;
    res_src_next    = res_src_reg;
    res_format_next = res_format_reg;
    ok_inc          = 2'b00;

    case (state_reg)
      ST_IDLE: begin
        if (grant_valid) begin
          chk_char_next = CH_START;
          owner_next    = grant_id;
          abort_next    = 1'b0;
          len_next      = '0;
          state_next    = ST_BUSY;
        end
      end
      ST_BUSY: begin
        if (own_fire) begin
          chk_char_next = own_char;
          len_next      = len_reg + LEN_W'(1);
          if (own_char == CH_END) begin
            state_next = ST_WAIT;
          end else if (len_reg == LEN_LAST) begin
            abort_next = 1'b1;
            state_next = ST_WAIT;
          end
        end else begin
          // Bubble: the checker sees a NUL, so the verdict cannot be trusted.
          abort_next = 1'b1;
        end
      end
      ST_WAIT: begin
        fmt_next   = chk_format;
        state_next = ST_REPORT;
      end
      ST_REPORT: begin
        res_valid_next  = 1'b1;
        res_src_next    = owner_reg;
        res_format_next = abort_reg ? FMT_INVALID : fmt_reg;
        if (!abort_reg && fmt_is_ok(fmt_reg)) begin
          ok_inc[owner_reg] = 1'b1;
        end
        state_next = ST_IDLE;
      end
      default: state_next = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      state_reg      <= ST_IDLE;
      chk_char_reg   <= CH_IDLE;
      owner_reg      <= 1'b0;
      abort_reg      <= 1'b0;
      len_reg        <= '0;
      fmt_reg        <= FMT_INVALID;
      res_valid_reg  <= 1'b0;
      res_src_reg    <= 1'b0;
      res_format_reg <= FMT_INVALID;
    end else begin
      state_reg      <= state_next;
      chk_char_reg   <= chk_char_next;
      owner_reg      <= owner_next;
      abort_reg      <= abort_next;
      len_reg        <= len_next;
      fmt_reg        <= fmt_next;
      res_valid_reg  <= res_valid_next;
      res_src_reg    <= res_src_next;
      res_format_reg <= res_format_next;
    end
  end

  for (genvar gi = 0; gi < 2; gi++) begin : g_cnt
    always_ff @(posedge clk) begin
      if (!reset) begin
        ok_cnt_reg[gi] <= 8'd0;
      end else if (ok_inc[gi]) begin
        ok_cnt_reg[gi] <= ok_cnt_reg[gi] + 8'd1;
      end
    end
  end

  assign req0_ready = ready[0];
  assign req1_ready = ready[1];
  assign chk_char   = chk_char_reg;
  assign res_valid  = res_valid_reg;
  assign res_src    = res_src_reg;
  assign res_format = res_format_reg;
  assign ok_cnt0    = ok_cnt_reg[0];
  assign ok_cnt1    = ok_cnt_reg[1];

endmodule

// File: tb/tb_checker_arbiter.sv
// Directed bench for checker_arbiter: grant, tie-break, bubble, length abort,
// IDLE filtering, mid-record reset and verdict counter wrap.
module tb_checker_arbiter;
  import checker_pkg::*;

  logic       clk = 1'b0;
  logic       reset;
  logic       req0_valid, req1_valid;
  logic [7:0] req0_char, req1_char;
  logic       req0_ready, req1_ready;
  logic [7:0] chk_char;
  logic [1:0] chk_format;
  logic       res_valid;
  logic       res_src;
  logic [1:0] res_format;
  logic [7:0] ok_cnt0, ok_cnt1;

  int checks = 0;
  int errors = 0;

  checker_arbiter #(.MAX_LEN(64)) dut (
    .clk        (clk),
    .reset      (reset),
    .req0_valid (req0_valid),
    .req1_valid (req1_valid),
    .req0_char  (req0_char),
    .req1_char  (req1_char),
    .req0_ready (req0_ready),
    .req1_ready (req1_ready),
    .chk_char   (chk_char),
    .chk_format (chk_format),
    .res_valid  (res_valid),
    .res_src    (res_src),
    .res_format (res_format),
    .ok_cnt0    (ok_cnt0),
    .ok_cnt1    (ok_cnt1)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic v0, input logic [7:0] c0, input logic v1, input logic [7:0] c1);
    req0_valid = v0;
    req0_char  = c0;
    req1_valid = v1;
    req1_char  = c1;
  endtask

  // One owner handshake: ready must be up, and the character appears next edge.
  task automatic send(input int r, input logic [7:0] ch);
    if (r == 0) drive(1'b1, ch, 1'b0, 8'h00);
    else        drive(1'b0, 8'h00, 1'b1, ch);
    #1;
    check("send_ready", (r == 0) ? req0_ready : req1_ready, 1'b1);
    tick();
    check("send_chk_char", chk_char, ch);
  endtask

  task automatic send_str(input int r, input string s);
    for (int i = 0; i < s.len(); i++) begin
      send(r, s[i]);
    end
  endtask

  // Entered one ns after the edge that took the last record character.
  task automatic finish_record(input logic src, input logic [1:0] fmt,
                               input logic [7:0] c0, input logic [7:0] c1);
    drive(1'b1, CH_START, 1'b1, CH_START);
    #1;
    check("wait_ready0", req0_ready, 1'b0);
    check("wait_ready1", req1_ready, 1'b0);
    drive(1'b0, 8'h00, 1'b0, 8'h00);
    tick();
    check("wait_chk_char", chk_char, CH_IDLE);
    check("early_res_valid", res_valid, 1'b0);
    drive(1'b1, CH_START, 1'b1, CH_START);
    #1;
    check("report_ready0", req0_ready, 1'b0);
    check("report_ready1", req1_ready, 1'b0);
    drive(1'b0, 8'h00, 1'b0, 8'h00);
    tick();
    check("res_valid", res_valid, 1'b1);
    check("res_src", res_src, src);
    check("res_format", res_format, fmt);
    check("ok_cnt0", ok_cnt0, c0);
    check("ok_cnt1", ok_cnt1, c1);
    $display("record src=%0d format=%0d ok_cnt0=%0d ok_cnt1=%0d",
             res_src, res_format, ok_cnt0, ok_cnt1);
    tick();
    check("res_valid_pulse", res_valid, 1'b0);
  endtask

  // Minimal "^#" record with no intermediate checks, for the counter wrap.
  task automatic quick_record(input int r);
    if (r == 0) drive(1'b1, CH_START, 1'b0, 8'h00);
    else        drive(1'b0, 8'h00, 1'b1, CH_START);
    tick();
    if (r == 0) drive(1'b1, CH_END, 1'b0, 8'h00);
    else        drive(1'b0, 8'h00, 1'b1, CH_END);
    tick();
    drive(1'b0, 8'h00, 1'b0, 8'h00);
    tick();
    tick();
  endtask

  initial begin
    reset      = 1'b0;
    chk_format = FMT_INVALID;
    drive(1'b0, 8'h00, 1'b0, 8'h00);

    // Reset state, with a '^' presented that must not be accepted.
    tick();
    drive(1'b1, CH_START, 1'b1, CH_START);
    #1;
    check("rst_ready0", req0_ready, 1'b0);
    check("rst_ready1", req1_ready, 1'b0);
    tick();
    check("rst_chk_char", chk_char, CH_IDLE);
    check("rst_res_valid", res_valid, 1'b0);
    check("rst_res_src", res_src, 1'b0);
    check("rst_res_format", res_format, FMT_INVALID);
    check("rst_ok_cnt0", ok_cnt0, 8'd0);
    check("rst_ok_cnt1", ok_cnt1, 8'd0);
    drive(1'b0, 8'h00, 1'b0, 8'h00);
    reset = 1'b1;
    tick();

    // Non-'^' characters in IDLE are consumed and dropped.
    drive(1'b1, 8'h61, 1'b0, 8'h00);
    #1;
    check("idle_a_ready", req0_ready, 1'b1);
    tick();
    check("idle_a_chk_char", chk_char, CH_IDLE);
    drive(1'b1, 8'h62, 1'b0, 8'h00);
    tick();
    check("idle_b_chk_char", chk_char, CH_IDLE);
    drive(1'b0, 8'h00, 1'b0, 8'h00);
    tick();
    check("idle_no_result", res_valid, 1'b0);
    check("idle_still_idle", chk_char, CH_IDLE);

    // First tie after reset goes to requester 0, the next to requester 1.
    chk_format = FMT_MEMORY;
    drive(1'b1, CH_START, 1'b1, CH_START);
    #1;
    check("tie1_ready0", req0_ready, 1'b1);
    check("tie1_ready1", req1_ready, 1'b1);
    tick();
    check("tie1_chk_char", chk_char, CH_START);
    send(0, CH_END);
    finish_record(1'b0, FMT_MEMORY, 8'd1, 8'd0);

    drive(1'b1, CH_START, 1'b1, CH_START);
    tick();
    check("tie2_chk_char", chk_char, CH_START);
    drive(1'b1, CH_END, 1'b0, 8'h00);
    #1;
    check("tie2_nonowner_ready0", req0_ready, 1'b0);
    send(1, CH_END);
    finish_record(1'b1, FMT_MEMORY, 8'd1, 8'd1);

    // Gapless register-format record from requester 0.
    chk_format = FMT_REGISTER;
    send_str(0, "^1024@000030fc:$2<=89abcdef#");
    finish_record(1'b0, FMT_REGISTER, 8'd2, 8'd1);

    // A one-cycle bubble from requester 1 forces a zero verdict.
    send_str(1, "^1");
    drive(1'b0, 8'h00, 1'b0, 8'h00);
    tick();
    check("bubble_chk_char", chk_char, CH_IDLE);
    send_str(1, "2#");
    finish_record(1'b1, FMT_INVALID, 8'd2, 8'd1);

    // 64 characters without '#': abort right after the 64th.
    send(0, CH_START);
    for (int i = 1; i < 64; i++) begin
      send(0, 8'h78);
    end
    finish_record(1'b0, FMT_INVALID, 8'd2, 8'd1);

    // Exactly 64 characters ending in '#' is a normal record.
    chk_format = FMT_MEMORY;
    send(0, CH_START);
    for (int i = 1; i < 63; i++) begin
      send(0, 8'h79);
    end
    send(0, CH_END);
    finish_record(1'b0, FMT_MEMORY, 8'd3, 8'd1);

    // Reset in the middle of a record discards it and clears the counters.
    send_str(1, "^1");
    reset = 1'b0;
    drive(1'b0, 8'h00, 1'b1, 8'h32);
    #1;
    check("midrst_ready1", req1_ready, 1'b0);
    tick();
    reset = 1'b1;
    drive(1'b0, 8'h00, 1'b0, 8'h00);
    check("midrst_chk_char", chk_char, CH_IDLE);
    check("midrst_res_valid", res_valid, 1'b0);
    check("midrst_res_format", res_format, FMT_INVALID);
    check("midrst_ok_cnt0", ok_cnt0, 8'd0);
    check("midrst_ok_cnt1", ok_cnt1, 8'd0);
    tick();
    check("midrst_res_valid_1", res_valid, 1'b0);
    tick();
    check("midrst_res_valid_2", res_valid, 1'b0);
    drive(1'b0, 8'h00, 1'b1, 8'h31);
    #1;
    check("midrst_idle_ready1", req1_ready, 1'b1);
    tick();
    check("midrst_idle_chk_char", chk_char, CH_IDLE);
    drive(1'b0, 8'h00, 1'b0, 8'h00);
    tick();
    check("midrst_no_result", res_valid, 1'b0);

    // Verdict counter wraps 255 -> 0.
    chk_format = FMT_REGISTER;
    for (int i = 0; i < 255; i++) begin
      quick_record(0);
    end
    check("wrap_ok_cnt0_255", ok_cnt0, 8'd255);
    check("wrap_ok_cnt1_0", ok_cnt1, 8'd0);
    quick_record(0);
    check("wrap_ok_cnt0_0", ok_cnt0, 8'd0);
    $display("record src=%0d format=%0d ok_cnt0=%0d ok_cnt1=%0d (after wrap)",
             res_src, res_format, ok_cnt0, ok_cnt1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/checker_arbiter.md
CHECKER_ARBITER -- requirements
Module: checker_arbiter

Interface
REQ-001 SHALL have parameter MAX_LEN, default 64, meaning the maximum characters per record, '^' and '#' inclusive.
REQ-002 SHALL have port clk  input  1  the single system clock; all state changes on its rising edge.
REQ-003 SHALL have port reset  input  1  synchronous, active-low reset.
REQ-004 SHALL have ports req0_valid / req1_valid  input  1  requester n presents a character.
REQ-005 SHALL have ports req0_char / req1_char  input  8  ASCII character from requester n.
REQ-006 SHALL have ports req0_ready / req1_ready  output  1  character accepted when valid && ready at a rising edge.
REQ-007 SHALL have port chk_char  output  8  registered character stream into the shared cpu_checker char input.
REQ-008 SHALL have port chk_format  input  2  cpu_checker format_type: 0 invalid, 1 register, 2 memory.
REQ-009 SHALL have port res_valid  output  1  one-cycle result strobe.
REQ-010 SHALL have ports res_src  output  1 and res_format  output  2: record owner and its verdict.
REQ-011 SHALL have ports ok_cnt0 / ok_cnt1  output  8  count of records with a nonzero verdict, per requester.

Function
REQ-012 SHALL implement states IDLE, BUSY, WAIT and REPORT.
REQ-013 In IDLE, SHALL assert ready to every valid requester; a non-'^' character (0x5E) SHALL be consumed and dropped, with no effect on chk_char.
REQ-014 In IDLE, a requester presenting '^' SHALL be granted, with chk_char <= '^' on the next edge and a move to BUSY.
REQ-015 If both requesters present '^' simultaneously, SHALL grant the requester not granted most recently; after reset, requester 0 SHALL win the first tie.
REQ-016 In BUSY, SHALL assert ready only to the owner and SHALL forward each accepted character to chk_char on the next edge.
REQ-017 A BUSY cycle without an owner handshake (bubble) SHALL drive chk_char=0x00 and set the abort flag; the record SHALL continue streaming.
REQ-018 Forwarding '#' (0x23) SHALL move the block to WAIT; chk_char SHALL return to 0x00 on the following edge.
REQ-019 In WAIT (one cycle), SHALL sample chk_format and move to REPORT.
REQ-020 In REPORT, SHALL hold res_valid=1 for exactly one cycle with res_src=owner, and res_format = abort ? 0 : sampled value, then return to IDLE.
REQ-021 Latency SHALL be: '#' handshake at edge E, res_valid high during the cycle after edge E+2.
REQ-022 A record reaching MAX_LEN characters without '#' SHALL be aborted: go to WAIT, then report format 0.
REQ-023 On a nonzero reported format, SHALL increment ok_cnt[res_src], wrapping 255 -> 0.
REQ-024 No new grant SHALL occur in WAIT or REPORT; ready SHALL be 0 for both requesters in those states.
REQ-025 The length counter SHALL be clog2(MAX_LEN)+1 bits and SHALL clear on each grant.

Reset
REQ-026 While reset=0 at a rising edge, SHALL enter IDLE with chk_char=0x00, both ready=0 for that cycle, res_valid=0, res_src=0, res_format=0, both ok_cnt=0, abort=0 and last-grant=1.
REQ-027 Reset asserted mid-record SHALL discard the record without emitting any result.

Structure
REQ-028 SHALL place state encodings, the constants CH_START=0x5E, CH_END=0x23 and CH_IDLE=0x00, and FMT_* codes in shared package checker_pkg.
REQ-029 SHALL isolate the two-way round-robin grant logic in sub-module rr_arb2.

Verification
REQ-030 Requester 0 streams "^1024@000030fc:$2<=89abcdef#" with no gaps; checker returns 1 -> res_valid, res_src=0, res_format=1, ok_cnt0=1.
REQ-031 Both requesters present '^' in the same cycle after reset -> requester 0 granted; repeated next time -> requester 1 granted.
REQ-032 Requester 1 deasserts valid for one cycle mid-record -> chk_char=0x00 that cycle; result res_format=0; ok_cnt1 unchanged.
REQ-033 A 64-character record without '#' -> abort after the 64th character; res_format=0.
REQ-034 Characters "ab" presented in IDLE -> consumed, chk_char stays 0x00, no result.
REQ-035 Reset pulsed during BUSY -> IDLE, no res_valid, counters 0.
